// File: rtl/rfid_poll_scheduler.sv
// rfid_poll_scheduler: periodic RFID poll sequencer with timeout, card de-duplication
// and a 4-entry tag table lookup, presenting one handshaked event per card.
module rfid_poll_scheduler #(
    parameter int POLL_PERIOD = 5_000_000,
    parameter int TIMEOUT     = 1_000_000,
    parameter int HOLD_POLLS  = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    output logic        rdr_start,
    input  logic        rdr_done,
    input  logic [31:0] rdr_uid,
    input  logic        tag_we,
    input  logic [1:0]  tag_addr,
    input  logic [31:0] tag_wdata,
    output logic        event_valid,
    input  logic        event_ready,
    output logic [31:0] event_uid,
    output logic        event_hit,
    output logic [1:0]  event_idx,
    output logic        timeout_err,
    output logic        busy
);
    localparam int PW = $clog2(POLL_PERIOD);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {IDLE, WAIT_PERIOD, START, WAIT_DONE, MATCH, EMIT} state_t;

    state_t      state, state_nxt;
    logic [PW-1:0] period_cnt;
    logic [TW-1:0] to_cnt;
    logic [31:0] cap_uid, last_uid;
    logic [3:0]  absent_cnt, absent_inc;
    logic [31:0] tags [4];
    logic        hit, new_card;
    logic [1:0]  idx;

    assign busy       = state != IDLE;
    assign new_card   = cap_uid != '0 && cap_uid != last_uid;
    assign absent_inc = absent_cnt >= 4'(HOLD_POLLS) ? absent_cnt : absent_cnt + 4'd1;

    // Scan downward so the lowest matching index is the one left standing
    always_comb begin
        hit = 1'b0;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--)
            if (tags[i] != '0 && tags[i] == cap_uid) begin
                hit = 1'b1;
                idx = 2'(i);
            end
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else      state <= state_nxt;

    always_comb begin
        state_nxt   = state;
        rdr_start   = 1'b0;
        timeout_err = 1'b0;
        event_valid = 1'b0;
        case (state)
            IDLE:        state_nxt = enable ? WAIT_PERIOD : IDLE;
            WAIT_PERIOD: state_nxt = !enable ? IDLE : (period_cnt == '0 ? START : WAIT_PERIOD);
            START: begin
                rdr_start = 1'b1;
                state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                timeout_err = !rdr_done && to_cnt == '0;
                state_nxt   = (rdr_done || to_cnt == '0) ? MATCH : WAIT_DONE;
            end
            MATCH:       state_nxt = new_card ? EMIT : (enable ? WAIT_PERIOD : IDLE);
            EMIT: begin
                event_valid = 1'b1;
                state_nxt   = !event_ready ? EMIT : (enable ? WAIT_PERIOD : IDLE);
            end
            default:     state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            period_cnt <= '0;
            to_cnt     <= '0;
            cap_uid    <= '0;
            last_uid   <= '0;
            absent_cnt <= '0;
            event_uid  <= '0;
            event_hit  <= 1'b0;
            event_idx  <= '0;
            for (int i = 0; i < 4; i++) tags[i] <= '0;
        end else begin
            if (tag_we) tags[tag_addr] <= tag_wdata;
            if (state_nxt == WAIT_PERIOD && state != WAIT_PERIOD) period_cnt <= PW'(POLL_PERIOD - 1);
            else if (state == WAIT_PERIOD && period_cnt != '0) period_cnt <= period_cnt - PW'(1);
            if (state == START) to_cnt <= TW'(TIMEOUT - 1);
            else if (state == WAIT_DONE && to_cnt != '0) to_cnt <= to_cnt - TW'(1);
            // A timed-out transaction is treated exactly like a reader reporting no card
            if (state == WAIT_DONE && (rdr_done || to_cnt == '0)) cap_uid <= rdr_done ? rdr_uid : '0;
            if (state == MATCH) begin
                if (cap_uid == '0) begin
                    absent_cnt <= absent_inc;
                    if (absent_inc == 4'(HOLD_POLLS)) last_uid <= '0;
                end else begin
                    absent_cnt <= '0;
                    if (new_card) begin
                        last_uid  <= cap_uid;
                        event_uid <= cap_uid;
                        event_hit <= hit;
                        event_idx <= idx;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_rfid_poll_scheduler.sv
// tb_rfid_poll_scheduler: directed scenarios with a transaction-level reader model,
// per-cycle output checks against predicted timing and events, plus literal pins.
module tb_rfid_poll_scheduler;
    localparam int P = 8, T = 20, H = 2;

    logic        clk = 0, rst = 0, enable = 0, rdr_done = 0, tag_we = 0, event_ready = 1;
    logic [31:0] rdr_uid = 0, tag_wdata = 0;
    logic [1:0]  tag_addr = 0;
    logic        rdr_start, event_valid, event_hit, timeout_err, busy;
    logic [31:0] event_uid;
    logic [1:0]  event_idx;

    rfid_poll_scheduler #(.POLL_PERIOD(P), .TIMEOUT(T), .HOLD_POLLS(H)) dut (
        .clk(clk), .rst(rst), .enable(enable), .rdr_start(rdr_start), .rdr_done(rdr_done),
        .rdr_uid(rdr_uid), .tag_we(tag_we), .tag_addr(tag_addr), .tag_wdata(tag_wdata),
        .event_valid(event_valid), .event_ready(event_ready), .event_uid(event_uid),
        .event_hit(event_hit), .event_idx(event_idx), .timeout_err(timeout_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { int d; logic [31:0] uid; } resp_t;
    resp_t       plan[$];
    resp_t       r;
    int          total = 0, bad = 0;
    int          n = 0, exp_start = -1, exp_to = -1, done_cyc = -1, match_cyc = -1, valid_from = 0, stray_cyc = -1;
    bit          ev_pending = 0, in_txn = 0, model_idle = 1, fs_pending = 0, prev_valid = 0, exp_valid;
    logic [31:0] cap = 0, last_uid = 0, done_uid = 0, ev_uid = 0;
    logic        ev_hit = 0;
    logic [1:0]  ev_idx = 0;
    int          absent = 0;
    logic [31:0] mtags [4] = '{default: 0};
    int          ev_count = 0, to_seen = 0, start_cnt = 0, start_cyc = 0, to_cyc = 0, acc_cyc = 0;
    int          en_cyc = 0, fs_cyc = 0, rise_cyc = 0, done_rec = 0;
    logic [31:0] got_uid = 0;
    logic        got_hit = 0;
    logic [1:0]  got_idx = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, n);
        end
    endtask

    task automatic finish_txn(input int c);
        exp_start  = enable ? c + P + 1 : -1;
        model_idle = !enable;
        in_txn     = 0;
    endtask

    // Apply the presence/dedupe rules and table lookup to one completed poll
    task automatic resolve(input int m);
        bit found;
        if (cap == 0) begin
            if (absent < H) absent++;
            if (absent == H) last_uid = 0;
            finish_txn(m);
        end else if (cap == last_uid) begin
            absent = 0;
            finish_txn(m);
        end else begin
            absent = 0; last_uid = cap; ev_uid = cap; ev_hit = 0; ev_idx = 0; found = 0;
            for (int i = 0; i < 4; i++)
                if (!found && mtags[i] != 0 && mtags[i] == cap) begin
                    found = 1; ev_hit = 1; ev_idx = 2'(i);
                end
            ev_pending = 1;
            valid_from = m + 1;
        end
    endtask

    initial forever begin
        @(negedge clk); #1;
        n++;
        if (rst && n == done_cyc) begin rdr_done = 1; rdr_uid = done_uid; done_rec = n; end
        else if (n == stray_cyc) begin rdr_done = 1; rdr_uid = 32'h99; end
        else begin rdr_done = 0; rdr_uid = 32'hDEAD0000; end
        #1;
        if (!rst) begin
            chk("rst_rdr_start", rdr_start, 0);
            chk("rst_event_valid", event_valid, 0);
            chk("rst_timeout_err", timeout_err, 0);
            chk("rst_busy", busy, 0);
            exp_start = -1; exp_to = -1; done_cyc = -1; match_cyc = -1;
            ev_pending = 0; in_txn = 0; model_idle = 1; fs_pending = 0; prev_valid = 0;
            last_uid = 0; absent = 0;
            for (int i = 0; i < 4; i++) mtags[i] = 0;
        end else begin
            chk("rdr_start", rdr_start, n == exp_start);
            chk("timeout_err", timeout_err, n == exp_to);
            exp_valid = ev_pending && n >= valid_from;
            chk("event_valid", event_valid, exp_valid);
            if (exp_valid) begin
                chk("event_uid", event_uid, ev_uid);
                chk("event_hit", event_hit, ev_hit);
                chk("event_idx", event_idx, ev_idx);
            end
            if (event_valid && !prev_valid) rise_cyc = n;
            prev_valid = event_valid;
            if (timeout_err) begin to_seen++; to_cyc = n; end
            if (rdr_start) begin
                start_cnt++; start_cyc = n; in_txn = 1; exp_start = -1;
                if (fs_pending) begin fs_cyc = n; fs_pending = 0; end
                if (plan.size() > 0) r = plan.pop_front();
                else begin r.d = 0; r.uid = 0; end
                if (r.d > 0) begin done_cyc = n + r.d; done_uid = r.uid; end
                else exp_to = n + T;
            end
            if (n == exp_to) begin cap = 0; match_cyc = n + 1; exp_to = -1; end
            if (n == done_cyc) begin cap = done_uid; match_cyc = n + 1; done_cyc = -1; end
            if (n == match_cyc) begin resolve(n); match_cyc = -1; end
            if (exp_valid && event_ready) begin
                ev_count++; acc_cyc = n; ev_pending = 0;
                got_uid = event_uid; got_hit = event_hit; got_idx = event_idx;
                finish_txn(n);
            end
            if (model_idle && enable) begin
                exp_start = n + P + 1; model_idle = 0; en_cyc = n; fs_pending = 1;
            end else if (!enable && !model_idle && !in_txn) begin
                model_idle = 1; exp_start = -1;
            end
        end
    end

    function automatic int cnt(input int sel);
        return sel == 0 ? ev_count : (sel == 1 ? to_seen : start_cnt);
    endfunction

    task automatic wt(input string nm, input int sel, input int k);
        for (int i = 0; i < 3000 && cnt(sel) < k; i++) @(negedge clk);
        if (cnt(sel) < k) chk(nm, cnt(sel), k);
    endtask

    task automatic wr_tag(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        tag_we = 1; tag_addr = a; tag_wdata = d; mtags[a] = d;
        @(negedge clk);
        tag_we = 0;
    endtask

    task automatic push(input int d, input logic [31:0] uid);
        resp_t e;
        e.d = d; e.uid = uid;
        plan.push_back(e);
    endtask

    int base, to_base, i;

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_event_uid", event_uid, 0);
        rst = 1;
        // Card present three polls, absent two polls, then back again
        wr_tag(2, 32'hABCDEF12);
        repeat (3) push(3, 32'hABCDEF12);
        repeat (2) push(4, 32'h0);
        push(2, 32'hABCDEF12);
        @(negedge clk); enable = 1;
        wt("wait_ev1", 0, 1);
        chk("ev1_uid", got_uid, 32'hABCDEF12);
        chk("ev1_hit", got_hit, 1);
        chk("ev1_idx", got_idx, 2);
        chk("ev1_latency", rise_cyc - done_rec, 2);
        chk("first_start_gap", fs_cyc - en_cyc, 9);
        wt("wait_ev2", 0, 2);
        chk("dedupe_events", ev_count, 2);
        chk("dedupe_plan_used", plan.size(), 0);
        // Reader silent: repeated timeouts, no events
        base = to_seen;
        wt("wait_timeouts", 1, base + 2);
        chk("timeout_gap", to_cyc - start_cyc, 20);
        chk("timeout_no_event", ev_count, 2);
        // Done on the expiring cycle wins over the timeout
        push(20, 32'h00000055);
        to_base = to_seen;
        wt("wait_ev3", 0, 3);
        chk("prio_no_timeout", to_seen, to_base);
        chk("miss_uid", got_uid, 32'h55);
        chk("miss_hit", got_hit, 0);
        chk("miss_idx", got_idx, 0);
        // Duplicate entries: lowest index wins
        @(negedge clk); enable = 0;
        for (i = 0; i < 100 && busy; i++) @(negedge clk);
        chk("disable_idle", busy, 0);
        wr_tag(0, 32'h12345678);
        wr_tag(3, 32'h12345678);
        push(5, 32'h12345678);
        @(negedge clk); enable = 1;
        wt("wait_ev4", 0, 4);
        chk("dup_hit", got_hit, 1);
        chk("dup_idx", got_idx, 0);
        // Consumer back-pressure
        event_ready = 0;
        push(3, 32'hCAFE0001);
        for (i = 0; i < 200 && !event_valid; i++) @(negedge clk);
        chk("bp_valid_rise", event_valid, 1);
        base = start_cnt;
        repeat (50) @(negedge clk);
        chk("bp_valid_held", event_valid, 1);
        chk("bp_uid_held", event_uid, 32'hCAFE0001);
        chk("bp_busy", busy, 1);
        chk("bp_no_start", start_cnt, base);
        event_ready = 1;
        wt("wait_ev5", 0, 5);
        wt("wait_start_after_accept", 2, base + 1);
        chk("accept_start_gap", start_cyc - acc_cyc, 9);
        // Reset during WAIT_DONE, then restart with a stray early done
        push(15, 32'h00000077);
        base = start_cnt;
        wt("wait_start_rst", 2, base + 1);
        repeat (4) @(negedge clk);
        rst = 0;
        #1;
        chk("arst_rdr_start", rdr_start, 0);
        chk("arst_busy", busy, 0);
        chk("arst_event_valid", event_valid, 0);
        chk("arst_timeout_err", timeout_err, 0);
        chk("arst_event_uid", event_uid, 0);
        chk("arst_event_hit", event_hit, 0);
        chk("arst_event_idx", event_idx, 0);
        repeat (2) @(negedge clk);
        stray_cyc = n + 3;
        push(2, 32'h99);
        base = start_cnt;
        rst = 1;
        wt("wait_start_post_rst", 2, base + 1);
        chk("post_rst_start_gap", fs_cyc - en_cyc, 9);
        wt("wait_ev6", 0, 6);
        chk("post_rst_uid", got_uid, 32'h99);
        chk("post_rst_hit", got_hit, 0);
        chk("post_rst_idx", got_idx, 0);
        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
